// File: rtl/pic_control_core.sv
// pic_control_core: single-mode 8259-style interrupt controller core (IRR/ISR/IMR, priority, ICW/OCW decode, INTA_ vector)
// Ports: CLK/RESET (async, active-high); WR_ENABLE/RD_ENABLE/A0/DATA_IN from the read/write logic;
//  DATA_OUT/DATA_OE read data or vector byte with bus enable; IR request lines; INTA_ active-low acknowledge;
//  INT request to CPU; INTA_COUNT acknowledge pulses seen; AEOI/LEVEL current modes.
module pic_control_core #(
  parameter int NUM_IR       = 8,
  parameter int SPURIOUS_IDX = 7
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WR_ENABLE,
  input  logic              RD_ENABLE,
  input  logic              A0,
  input  logic [7:0]        DATA_IN,
  output logic [7:0]        DATA_OUT,
  output logic              DATA_OE,
  input  logic [NUM_IR-1:0] IR,
  input  logic              INTA_,
  output logic              INT,
  output logic [1:0]        INTA_COUNT,
  output logic              AEOI,
  output logic              LEVEL
);
  typedef enum logic [2:0] {ICW1_WAIT, ICW2, ICW3, ICW4, READY} init_t;
  typedef enum logic [1:0] {IDLE, ACK1, ACK2} inta_t;
  init_t init_q, init_d;
  inta_t inta_st_q, inta_st_d;
  logic [7:0] imr_q, imr_d, irr_q, irr_d, isr_q, isr_d, ir_q, ir_ext;
  logic [4:0] base_q, base_d;
  logic [2:0] lp_q, lp_d, idx_q, idx_d, eoi_lvl;
  logic       aeoi_q, aeoi_d, level_q, level_d, sngl_q, sngl_d, ic4_q, ic4_d;
  logic       ris_q, ris_d, rot_q, rot_d, spur_q, spur_d, int_q, int_d, inta_q;
  logic [6:0] req_p, isr_p;
  logic       fall, rise, icw1, ready, ocw2, ocw3, rd_act, vec_oe;
  // {found, rank, level}: rank 0 is level lp+1, the highest priority
  function automatic logic [6:0] prio(input logic [7:0] v, input logic [2:0] lp);
    logic [6:0] r;
    logic [2:0] l;
    r = '0;
    for (int k = 7; k >= 0; k--) begin
      l = lp + 3'(k + 1);
      if (v[l]) r = {1'b1, 3'(k), l};
    end
    return r;
  endfunction
  // lines NUM_IR..7 read as zero, so they can never request
  assign ir_ext = 8'(IR);
  assign req_p  = prio(irr_q & ~imr_q, lp_q);
  assign isr_p  = prio(isr_q, lp_q);
  assign fall   = inta_q & ~INTA_;
  assign rise   = ~inta_q & INTA_;
  assign icw1   = WR_ENABLE & ~A0 & DATA_IN[4];
  assign ready  = init_q == READY;
  assign ocw2   = ready & WR_ENABLE & ~A0 & ~DATA_IN[4] & ~DATA_IN[3];
  assign ocw3   = ready & WR_ENABLE & ~A0 & ~DATA_IN[4] & DATA_IN[3];
  always_comb begin
    init_d    = init_q;
    inta_st_d = inta_st_q;
    imr_d     = imr_q;
    isr_d     = isr_q;
    base_d    = base_q;
    lp_d      = lp_q;
    idx_d     = idx_q;
    aeoi_d    = aeoi_q;
    level_d   = level_q;
    sngl_d    = sngl_q;
    ic4_d     = ic4_q;
    ris_d     = ris_q;
    rot_d     = rot_q;
    spur_d    = spur_q;
    eoi_lvl   = DATA_IN[6] ? DATA_IN[2:0] : isr_p[2:0];
    // edge mode: set on a registered 0->1, drop whenever the pin is low
    irr_d     = level_q ? ir_ext : (irr_q | ~ir_q) & ir_ext;
    if (WR_ENABLE && A0) begin
      if (init_q == ICW2) begin
        base_d = DATA_IN[7:3];
        init_d = !sngl_q ? ICW3 : ic4_q ? ICW4 : READY;
      end
      if (init_q == ICW3) init_d = ic4_q ? ICW4 : READY;
      if (init_q == ICW4) begin
        aeoi_d = DATA_IN[1];
        init_d = READY;
      end
      if (ready) imr_d = DATA_IN;
    end
    if (ocw3 && DATA_IN[1]) ris_d = DATA_IN[0];
    // EOI is applied to the pre-edge ISR; a same-cycle acknowledge then sets its bit below
    if (ocw2) begin
      rot_d = DATA_IN[7];
      if (DATA_IN[5] && (DATA_IN[6] || isr_p[6])) begin
        isr_d[eoi_lvl] = 1'b0;
        if (DATA_IN[7]) lp_d = eoi_lvl;
      end else if (DATA_IN[7:5] == 3'b110) lp_d = DATA_IN[2:0];
    end
    if (inta_st_q == IDLE && fall) begin
      inta_st_d = ACK1;
      spur_d    = ~req_p[6];
      idx_d     = req_p[6] ? req_p[2:0] : 3'(SPURIOUS_IDX);
      if (req_p[6]) begin
        isr_d[req_p[2:0]] = 1'b1;
        if (!level_q) irr_d[req_p[2:0]] = 1'b0;
      end
    end
    if (inta_st_q == ACK1 && fall) inta_st_d = ACK2;
    if (inta_st_q == ACK2 && rise) begin
      inta_st_d = IDLE;
      if (aeoi_q && !spur_q) begin
        isr_d[idx_q] = 1'b0;
        if (rot_q) lp_d = idx_q;
      end
    end
    if (icw1) begin
      init_d    = ICW2;
      inta_st_d = IDLE;
      imr_d     = '0;
      isr_d     = '0;
      irr_d     = '0;
      lp_d      = 3'd7;
      aeoi_d    = 1'b0;
      level_d   = DATA_IN[3];
      sngl_d    = DATA_IN[1];
      ic4_d     = DATA_IN[0];
    end
    int_d = ready & (inta_st_q == IDLE) & ~fall & ~icw1 & req_p[6] & (~isr_p[6] | (req_p[5:3] < isr_p[5:3]));
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      init_q    <= ICW1_WAIT;
      inta_st_q <= IDLE;
      imr_q     <= 8'hFF;
      irr_q     <= '0;
      isr_q     <= '0;
      ir_q      <= '0;
      base_q    <= '0;
      lp_q      <= 3'd7;
      idx_q     <= '0;
      aeoi_q    <= 1'b0;
      level_q   <= 1'b0;
      sngl_q    <= 1'b0;
      ic4_q     <= 1'b0;
      ris_q     <= 1'b0;
      rot_q     <= 1'b0;
      spur_q    <= 1'b0;
      int_q     <= 1'b0;
      inta_q    <= 1'b1;
    end else begin
      init_q    <= init_d;
      inta_st_q <= inta_st_d;
      imr_q     <= imr_d;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      ir_q      <= ir_ext;
      base_q    <= base_d;
      lp_q      <= lp_d;
      idx_q     <= idx_d;
      aeoi_q    <= aeoi_d;
      level_q   <= level_d;
      sngl_q    <= sngl_d;
      ic4_q     <= ic4_d;
      ris_q     <= ris_d;
      rot_q     <= rot_d;
      spur_q    <= spur_d;
      int_q     <= int_d;
      inta_q    <= INTA_;
    end
  end
  assign rd_act     = RD_ENABLE & (inta_st_q == IDLE);
  assign vec_oe     = (inta_st_q == ACK2) & ~INTA_;
  assign DATA_OE    = vec_oe | rd_act;
  assign DATA_OUT   = vec_oe ? {base_q, idx_q} : rd_act ? (A0 ? imr_q : ris_q ? isr_q : irr_q) : 8'h00;
  assign INT        = int_q;
  assign INTA_COUNT = inta_st_q == ACK1 ? 2'd1 : inta_st_q == ACK2 ? 2'd2 : 2'd0;
  assign AEOI       = aeoi_q;
  assign LEVEL      = level_q;
endmodule

// File: tb/tb_pic_control_core.sv
// tb_pic_control_core: directed scoreboard bench for pic_control_core
module tb_pic_control_core;
  logic       clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0, a0 = 1'b0, inta_n = 1'b1;
  logic [7:0] din = '0, ir = '0, dout;
  logic       doe, intr, aeoi, level;
  logic [1:0] cnt;
  int         checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];
  pic_control_core #(.NUM_IR(8), .SPURIOUS_IDX(7)) dut (
    .CLK(clk), .RESET(rst), .WR_ENABLE(wr_en), .RD_ENABLE(rd_en), .A0(a0), .DATA_IN(din),
    .DATA_OUT(dout), .DATA_OE(doe), .IR(ir), .INTA_(inta_n), .INT(intr), .INTA_COUNT(cnt),
    .AEOI(aeoi), .LEVEL(level)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input string t, input logic [7:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask
  task automatic chk(input logic [7:0] obs);
    logic [7:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask
  task automatic wr(input logic a, input logic [7:0] d);
    wr_en = 1'b1;
    a0 = a;
    din = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic rd(input logic a, input string t, input logic [7:0] v);
    push(t, v);
    rd_en = 1'b1;
    a0 = a;
    #1;
    chk(dout);
    rd_en = 1'b0;
  endtask
  task automatic check_int(input string t, input logic v);
    push(t, 8'(v));
    chk(8'(intr));
  endtask
  task automatic ack(input string t, input logic [7:0] vec);
    push({t, "_cnt1"}, 8'd1);
    inta_n = 1'b0;
    tick();
    chk(8'(cnt));
    inta_n = 1'b1;
    tick();
    push({t, "_cnt2"}, 8'd2);
    push({t, "_oe"}, 8'd1);
    push({t, "_vec"}, vec);
    inta_n = 1'b0;
    tick();
    chk(8'(cnt));
    chk(8'(doe));
    chk(dout);
    push({t, "_end_cnt"}, 8'd0);
    push({t, "_end_oe"}, 8'd0);
    inta_n = 1'b1;
    tick();
    chk(8'(cnt));
    chk(8'(doe));
  endtask
  task automatic init(input logic [7:0] w4);
    wr(1'b0, 8'h13);
    wr(1'b1, 8'hF8);
    wr(1'b1, w4);
    wr(1'b0, 8'h0B);
  endtask
  initial begin
    tick(2);
    push("rst_int", 8'd0); chk(8'(intr));
    push("rst_oe", 8'd0); chk(8'(doe));
    push("rst_dout", 8'd0); chk(dout);
    push("rst_cnt", 8'd0); chk(8'(cnt));
    push("rst_modes", 8'd0); chk({6'd0, aeoi, level});
    rd(1'b1, "rst_imr", 8'hFF);
    rd(1'b0, "rst_irr", 8'h00);
    rst = 1'b0;
    tick();
    init(8'h01);
    push("init_modes", 8'd0); chk({6'd0, aeoi, level});
    rd(1'b1, "init_imr", 8'h00);
    ir = 8'h08;
    tick();
    check_int("ir3_latency", 1'b0);
    tick();
    check_int("ir3_int", 1'b1);
    ack("ir3", 8'hFB);
    rd(1'b0, "ir3_isr", 8'h08);
    check_int("ir3_no_reint", 1'b0);
    wr(1'b0, 8'h20);
    rd(1'b0, "eoi_isr", 8'h00);
    wr(1'b1, 8'h08);
    ir = 8'h00;
    tick();
    ir = 8'h08;
    tick(3);
    check_int("masked_ir3", 1'b0);
    ir = 8'h00;
    rd(1'b1, "imr_read", 8'h08);
    wr(1'b1, 8'h00);
    ir = 8'h20;
    tick(2);
    check_int("ir5_int", 1'b1);
    ack("ir5", 8'hFD);
    ir = 8'h24;
    tick(2);
    check_int("ir2_over_ir5", 1'b1);
    ir = 8'h20;
    tick(2);
    check_int("ir2_dropped", 1'b0);
    ir = 8'h60;
    tick(3);
    check_int("ir6_under_ir5", 1'b0);
    wr(1'b0, 8'h20);
    check_int("eoi_lag", 1'b0);
    tick();
    check_int("ir6_after_eoi", 1'b1);
    ir = 8'h00;
    tick();
    init(8'h03);
    push("aeoi_mode", 8'd2); chk({6'd0, aeoi, level});
    ir = 8'h01;
    tick(2);
    check_int("ir0_int", 1'b1);
    ack("ir0", 8'hF8);
    rd(1'b0, "aeoi_isr", 8'h00);
    wr(1'b0, 8'hA0);
    ir = 8'h00;
    tick();
    ir = 8'h03;
    tick(2);
    ack("rot_ir0", 8'hF8);
    tick();
    check_int("rot_ir1_int", 1'b1);
    ack("rot_ir1", 8'hF9);
    rd(1'b0, "rot_isr", 8'h00);
    ir = 8'h00;
    tick();
    init(8'h01);
    ir = 8'h40;
    tick(2);
    ack("ir6", 8'hFE);
    ir = 8'h50;
    tick(2);
    check_int("ir4_int", 1'b1);
    ir = 8'h40;
    tick();
    ack("spurious", 8'hFF);
    rd(1'b0, "spur_isr", 8'h40);
    ir = 8'h50;
    tick(2);
    push("pre_rst_cnt", 8'd1);
    inta_n = 1'b0;
    tick();
    chk(8'(cnt));
    rst = 1'b1;
    inta_n = 1'b1;
    ir = 8'h00;
    #1;
    push("arst_int", 8'd0); chk(8'(intr));
    push("arst_oe", 8'd0); chk(8'(doe));
    push("arst_cnt", 8'd0); chk(8'(cnt));
    rd(1'b1, "arst_imr", 8'hFF);
    tick();
    rst = 1'b0;
    tick();
    init(8'h01);
    ir = 8'h08;
    tick(2);
    inta_n = 1'b0;
    tick();
    inta_n = 1'b1;
    tick();
    wr(1'b0, 8'h13);
    push("icw1_abort_cnt", 8'd0); chk(8'(cnt));
    wr(1'b1, 8'hF8);
    wr(1'b1, 8'h01);
    wr(1'b0, 8'h0B);
    rd(1'b0, "icw1_abort_isr", 8'h00);
    check_int("icw1_abort_int", 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
